commit_trace_streamer: RTL and testbench
========================================

# commit_trace_streamer

Hardware commit-trace transmitter for the RV32 single-cycle core. It captures each retired-instruction record that the core presents on its trace outputs (`update`, `pc`, `instr`, `reg_addr`, `reg_data`) into a small FIFO. It then serializes each record as a byte stream over a valid/ready link toward an off-chip log sink. A host can rebuild the same per-instruction log on silicon that the simulation bench writes to `model.log`.

## Interface
Parameters:
- `DEPTH`, default 8: FIFO depth in records; must be a power of 2, ≥2.
- `CNT_W`, default 16: width of the drop counter.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset; asynchronous, active-high.
- `update_i` in 1: a record is valid this cycle.
- `pc_i` in XLEN(32): committed PC.
- `instr_i` in 32: committed instruction word.
- `reg_addr_i` in 5: destination register; 0 means no write-back.
- `reg_data_i` in XLEN(32): write-back value.
- `tx_valid_o` out 1: output byte valid.
- `tx_data_o` out 8: output byte.
- `tx_ready_i` in 1: sink accepts the byte.
- `level_o` out $clog2(DEPTH)+1: records currently held in the FIFO.
- `drop_cnt_o` out CNT_W: records lost to overflow; saturating.
- `busy_o` out 1: high while the FIFO is non-empty or a record is in transmission.

## Operation
- **Capture**
  - On each rising edge with `update_i`=1, the record {pc, instr, reg_addr, reg_data} is pushed if `level_o` < DEPTH.
  - Otherwise the record is dropped and `drop_cnt_o` increments, saturating at 2^CNT_W−1.
  - Fullness is judged on the pre-edge level. A pop on the same edge does not make room.
- **Frame format**, bytes in order:
  - Header: {3'b101, reg_addr}.
  - PC: 4 bytes, little-endian.
  - INSTR: 4 bytes, little-endian.
  - DATA: 4 bytes, little-endian, sent only when reg_addr≠0.
  - A frame is therefore 9 or 13 bytes.
- **FSM states:** IDLE, HDR, PC, INSTR, DATA. A 2-bit byte index runs inside the PC, INSTR and DATA states.
  - IDLE → HDR when the FIFO is non-empty. The head record is popped into a shadow register on this transition.
  - HDR → PC on handshake.
  - PC → INSTR on the 4th PC handshake.
  - INSTR → DATA on the 4th INSTR handshake if reg_addr≠0. Otherwise INSTR → HDR if the FIFO is non-empty (popping the next record), else INSTR → IDLE.
  - DATA → HDR or IDLE on the 4th DATA handshake, using the same rule as INSTR.
- **Handshake**
  - A byte transfers on an edge where `tx_valid_o` and `tx_ready_i` are both high.
  - While `tx_valid_o`=1 and `tx_ready_i`=0, `tx_data_o` must hold stable.
  - Once raised, `tx_valid_o` never drops until the frame completes.
- **Ordering:** frames leave in capture order. Records are never reordered or merged.

## Timing
- Reset values: `tx_valid_o`=0, `tx_data_o`=0, `level_o`=0, `drop_cnt_o`=0, `busy_o`=0, FSM=IDLE.
- Asserting `rst_i` mid-frame immediately aborts the frame, with `tx_valid_o` going low asynchronously, and empties the FIFO.
- Latency: `update_i` sampled at edge N with the FIFO empty and the FSM in IDLE gives `tx_valid_o`=1 with the header byte after edge N+1.
- `level_o` reflects the push after edge N.
- With `tx_ready_i` held at 1, the next byte presents the cycle after each handshake. A 13-byte frame therefore occupies 13 consecutive cycles.
- Back-to-back frames have no idle cycle between the last byte of one and the header of the next.
- `busy_o` falls the cycle after the final handshake if the FIFO is empty.

## Structure
- `riscv_pkg` gains the trace definitions:
  - `trace_rec_t` packed struct {pc, instr, reg_addr, reg_data}.
  - `TRACE_HDR_TAG`=3'b101.
  - A `trace_state_e` enum.
- One sub-module, `trace_fifo`: a synchronous FIFO of `trace_rec_t` with DEPTH entries.
  - Push and pop ports, with full, empty and level outputs.
  - Asynchronous active-high reset.
- The FSM, shadow register, byte mux and drop counter live in the top module.

## Test plan
1. **Single write-back record.** Inputs: pc=0x80000000, instr=0x00500293, reg_addr=5, reg_data=0xDEADBEEF; `tx_ready_i`=1.
   - Required bytes: A5 00 00 00 80 93 02 50 00 EF BE AD DE, over 13 consecutive cycles.
   - `busy_o` must then fall.
2. **No write-back.** Inputs: reg_addr=0, pc=0x80000004, instr=0x00000013.
   - Required bytes: A0 04 00 00 80 13 00 00 00, 9 bytes only.
3. **Backpressure.** Drop `tx_ready_i` for 5 cycles while the 2nd PC byte is presented.
   - `tx_data_o` must stay 0x00 with `tx_valid_o`=1 throughout.
   - The stream resumes with no byte lost or duplicated.
4. **Overflow.** With `tx_ready_i`=0 and DEPTH=8, issue 10 consecutive updates with pc=0x100+4k.
   - Requires `level_o`=8 and `drop_cnt_o`=2.
   - Once ready is released, 8 frames drain with PCs 0x100..0x11C in order.
5. **Reset mid-frame.** Assert `rst_i` during INSTR byte 2.
   - `tx_valid_o` goes 0 without waiting for a clock edge; `level_o`=0 and `drop_cnt_o`=0.
   - After release, a new update produces a fresh header as its first byte.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: commit-trace record layout, frame tag and
// the serializer state encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  // Upper three bits of every frame header byte.
  localparam logic [2:0] TRACE_HDR_TAG = 3'b101;

  // One retired-instruction record as presented by the core.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [4:0]      reg_addr;
    logic [XLEN-1:0] reg_data;
  } trace_rec_t;

  // Serializer states; the byte index runs inside PC, INSTR and DATA.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_PC    = 3'd2,
    ST_INSTR = 3'd3,
    ST_DATA  = 3'd4
  } trace_state_e;

  // Little-endian byte select from a 32-bit word.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/commit_trace_streamer_fifo.sv
// Synchronous FIFO of trace records. Pointers carry one extra wrap bit so
// full and empty are distinguished without a separate counter.
module trace_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  trace_rec_t wr_data,
  input  logic       pop,
  output trace_rec_t rd_data,
  output logic       full,
  output logic       empty,
  output logic [AW:0] level
);

  trace_rec_t   mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Storage array; contents need no reset because empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Read and write pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/commit_trace_streamer.sv
// Commit-trace transmitter: buffers retired-instruction records and
// serializes each as a 9- or 13-byte frame over a valid/ready byte link.
//
// Handshake: a byte moves on a rising edge where tx_valid_o and tx_ready_i
// are both high. tx_valid_o and tx_data_o derive only from registered state,
// so they hold steady under backpressure, and valid stays high from header
// to the final byte of a frame.
module commit_trace_streamer
  import riscv_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     update_i,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [31:0]              instr_i,
  input  logic [4:0]               reg_addr_i,
  input  logic [XLEN-1:0]          reg_data_i,
  output logic                     tx_valid_o,
  output logic [7:0]               tx_data_o,
  input  logic                     tx_ready_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [CNT_W-1:0]         drop_cnt_o,
  output logic                     busy_o,
  output logic [2:0]               state_o
);

  trace_state_e state_q, state_d;
  logic [1:0]   idx_q, idx_d;
  trace_rec_t   shadow_q;
  trace_rec_t   in_rec;
  trace_rec_t   head_rec;
  logic         fifo_full;
  logic         fifo_empty;
  logic         pop;
  logic         hs;
  logic         frame_done;

  assign in_rec     = '{pc: pc_i, instr: instr_i, reg_addr: reg_addr_i, reg_data: reg_data_i};
  assign tx_valid_o = (state_q != ST_IDLE);
  assign hs         = tx_valid_o && tx_ready_i;
  assign busy_o     = tx_valid_o || !fifo_empty;
  assign state_o    = state_q;

  // Fullness is judged on the pre-edge level inside the FIFO, so a pop on
  // the same edge never makes room for an incoming record.
  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .push    (update_i),
    .wr_data (in_rec),
    .pop     (pop),
    .rd_data (head_rec),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level_o)
  );

  // Saturating count of records lost to a full FIFO.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drop_cnt_o <= '0;
    end else if (update_i && fifo_full && (drop_cnt_o != {CNT_W{1'b1}})) begin
      drop_cnt_o <= drop_cnt_o + 1'b1;
    end
  end

  // FSM state, byte index and the shadow copy of the record in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      idx_q    <= 2'd0;
      shadow_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (pop) shadow_q <= head_rec;
    end
  end

  // Next-state logic; a finished frame chains straight into the next header.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pop        = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_HDR;
          pop     = 1'b1;
          idx_d   = 2'd0;
        end
      end
      ST_HDR: begin
        if (hs) begin
          state_d = ST_PC;
          idx_d   = 2'd0;
        end
      end
      ST_PC: begin
        if (hs) begin
          if (idx_q == 2'd3) begin
            state_d = ST_INSTR;
            idx_d   = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      ST_INSTR: begin
        if (hs) begin
          if (idx_q == 2'd3) begin
            if (shadow_q.reg_addr != 5'd0) begin
              state_d = ST_DATA;
              idx_d   = 2'd0;
            end else begin
              frame_done = 1'b1;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      ST_DATA: begin
        if (hs) begin
          if (idx_q == 2'd3) frame_done = 1'b1;
          else               idx_d = idx_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (frame_done) begin
      idx_d = 2'd0;
      if (!fifo_empty) begin
        state_d = ST_HDR;
        pop     = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // Byte mux: the presented byte is a pure function of state, index and shadow.
  always_comb begin
    tx_data_o = 8'h00;
    case (state_q)
      ST_HDR:   tx_data_o = {TRACE_HDR_TAG, shadow_q.reg_addr};
      ST_PC:    tx_data_o = word_byte(shadow_q.pc, idx_q);
      ST_INSTR: tx_data_o = word_byte(shadow_q.instr, idx_q);
      ST_DATA:  tx_data_o = word_byte(shadow_q.reg_data, idx_q);
      default:  tx_data_o = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_commit_trace_streamer.sv
// Directed bench for commit_trace_streamer with a byte scoreboard.
module tb_commit_trace_streamer;
  import riscv_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic                   clk_i;
  logic                   rst_i;
  logic                   update_i;
  logic [31:0]            pc_i;
  logic [31:0]            instr_i;
  logic [4:0]             reg_addr_i;
  logic [31:0]            reg_data_i;
  logic                   tx_valid_o;
  logic [7:0]             tx_data_o;
  logic                   tx_ready_i;
  logic [$clog2(DEPTH):0] level_o;
  logic [CNT_W-1:0]       drop_cnt_o;
  logic                   busy_o;
  logic [2:0]             state_o;

  logic [7:0] exp_q[$];
  int compared   = 0;
  int mismatched = 0;

  commit_trace_streamer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .update_i   (update_i),
    .pc_i       (pc_i),
    .instr_i    (instr_i),
    .reg_addr_i (reg_addr_i),
    .reg_data_i (reg_data_i),
    .tx_valid_o (tx_valid_o),
    .tx_data_o  (tx_data_o),
    .tx_ready_i (tx_ready_i),
    .level_o    (level_o),
    .drop_cnt_o (drop_cnt_o),
    .busy_o     (busy_o),
    .state_o    (state_o)
  );

  // Clock and watchdog
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Expected frame built from the record fields.
  task automatic push_frame(input logic [31:0] pc, input logic [31:0] instr,
                            input logic [4:0] ra, input logic [31:0] rd);
    exp_q.push_back({3'b101, ra});
    for (int i = 0; i < 4; i++) exp_q.push_back(pc[8*i +: 8]);
    for (int i = 0; i < 4; i++) exp_q.push_back(instr[8*i +: 8]);
    if (ra != 5'd0)
      for (int i = 0; i < 4; i++) exp_q.push_back(rd[8*i +: 8]);
  endtask

  task automatic set_rec(input logic [31:0] pc, input logic [31:0] instr,
                         input logic [4:0] ra, input logic [31:0] rd);
    update_i   = 1'b1;
    pc_i       = pc;
    instr_i    = instr;
    reg_addr_i = ra;
    reg_data_i = rd;
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  // Scoreboard: every accepted byte is popped and compared.
  always @(negedge clk_i) begin
    if (!rst_i && tx_valid_o && tx_ready_i) begin
      compared++;
      assert (exp_q.size() != 0) else begin
        mismatched++;
        $error("FAIL extra_byte: observed 0x%0h expected none", tx_data_o);
      end
      if (exp_q.size() != 0) check("tx_byte", tx_data_o, exp_q.pop_front());
    end
  end

  initial begin
    rst_i = 1'b1; update_i = 1'b0; pc_i = '0; instr_i = '0;
    reg_addr_i = '0; reg_data_i = '0; tx_ready_i = 1'b1;
    tick(); tick();
    check("rst_valid", tx_valid_o, 0);
    check("rst_data", tx_data_o, 0);
    check("rst_level", level_o, 0);
    check("rst_drop", drop_cnt_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_state", state_o, ST_IDLE);
    rst_i = 1'b0;
    tick();

    // 1: single write-back record, 13 consecutive bytes
    set_rec(32'h80000000, 32'h00500293, 5'd5, 32'hDEADBEEF);
    push_frame(32'h80000000, 32'h00500293, 5'd5, 32'hDEADBEEF);
    tick();
    update_i = 1'b0;
    check("t1_level_after_push", level_o, 1);
    check("t1_valid_before", tx_valid_o, 0);
    tick();
    check("t1_hdr", tx_data_o, 8'hA5);
    for (int i = 0; i < 13; i++) begin
      check("t1_valid_run", tx_valid_o, 1);
      tick();
    end
    check("t1_busy_fall", busy_o, 0);
    check("t1_valid_fall", tx_valid_o, 0);
    check("t1_queue", exp_q.size(), 0);

    // 2: no write-back, 9 bytes only
    set_rec(32'h80000004, 32'h00000013, 5'd0, 32'h12345678);
    push_frame(32'h80000004, 32'h00000013, 5'd0, 32'h12345678);
    tick();
    update_i = 1'b0;
    tick();
    check("t2_hdr", tx_data_o, 8'hA0);
    for (int i = 0; i < 9; i++) begin
      check("t2_valid_run", tx_valid_o, 1);
      tick();
    end
    check("t2_busy_fall", busy_o, 0);
    check("t2_queue", exp_q.size(), 0);

    // 3: backpressure on the second PC byte
    set_rec(32'h80000000, 32'h00500293, 5'd5, 32'hDEADBEEF);
    push_frame(32'h80000000, 32'h00500293, 5'd5, 32'hDEADBEEF);
    tick();
    update_i = 1'b0;
    tick(); tick(); tick();
    tx_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", tx_valid_o, 1);
      check("t3_hold_data", tx_data_o, 8'h00);
      check("t3_hold_state", state_o, ST_PC);
      tick();
    end
    tx_ready_i = 1'b1;
    wait_drain(100, "t3_drain");
    check("t3_busy", busy_o, 0);

    // 4: overflow while a frame is stalled in its header
    tx_ready_i = 1'b0;
    set_rec(32'h00000200, 32'h00000013, 5'd0, 32'h0);
    push_frame(32'h00000200, 32'h00000013, 5'd0, 32'h0);
    tick();
    update_i = 1'b0;
    tick();
    check("t4_stalled_hdr", tx_valid_o, 1);
    for (int k = 0; k < 10; k++) begin
      set_rec(32'h100 + 32'(4*k), 32'h00100093 + 32'(k), 5'(k), 32'hC0DE0000 + 32'(k));
      if (k < 8) push_frame(32'h100 + 32'(4*k), 32'h00100093 + 32'(k), 5'(k), 32'hC0DE0000 + 32'(k));
      tick();
    end
    update_i = 1'b0;
    check("t4_level_full", level_o, 8);
    check("t4_drop_cnt", drop_cnt_o, 2);
    tx_ready_i = 1'b1;
    wait_drain(400, "t4_drain");
    check("t4_level_empty", level_o, 0);
    check("t4_busy", busy_o, 0);

    // 5: reset in the middle of INSTR byte 2
    set_rec(32'h80000010, 32'h12345678, 5'd3, 32'h55AA55AA);
    push_frame(32'h80000010, 32'h12345678, 5'd3, 32'h55AA55AA);
    tick();
    update_i = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) tick();
    check("t5_instr_b2", tx_data_o, 8'h34);
    check("t5_state_instr", state_o, ST_INSTR);
    #2;
    rst_i = 1'b1;
    exp_q.delete();
    #1;
    check("t5_async_valid", tx_valid_o, 0);
    check("t5_level", level_o, 0);
    check("t5_drop", drop_cnt_o, 0);
    check("t5_busy", busy_o, 0);
    check("t5_state", state_o, ST_IDLE);
    tick();
    rst_i = 1'b0;
    tick();
    set_rec(32'h80000020, 32'h00000013, 5'd0, 32'h0);
    push_frame(32'h80000020, 32'h00000013, 5'd0, 32'h0);
    tick();
    update_i = 1'b0;
    tick();
    check("t5_fresh_valid", tx_valid_o, 1);
    check("t5_fresh_hdr", tx_data_o, 8'hA0);
    wait_drain(100, "t5_drain");
    check("t5_busy_end", busy_o, 0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
